bomb_ctrl: RTL and testbench

Bomb-side responder to a player controller's bomb_drop request. It latches the dropping player's position, snapped to the tile grid, and runs a fuse countdown. It then publishes an expanded blast region, which the opposing player controller consumes on its bombX/Y/S inputs, and counts hits reported back on collide. There is one instance per player, clocked by the frame clock.

---
 rtl/bomb_ctrl_if.sv | 21 ++
 rtl/bomb_ctrl.sv | 108 ++++++++++
 tb/tb_bomb_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/bomb_ctrl_if.sv
// bomb_ctrl_if: drop request, player position and collide in; published region, status and hit count out.
interface bomb_ctrl_if;
    logic       bomb_drop;
    logic [9:0] userX;
    logic [9:0] userY;
    logic       collide;
    logic [9:0] bombX;
    logic [9:0] bombY;
    logic [9:0] bombS;
    logic       bomb_live;
    logic       blast;
    logic [2:0] hit_count;
    modport master (
        output bomb_drop, userX, userY, collide,
        input  bombX, bombY, bombS, bomb_live, blast, hit_count
    );
    modport slave (
        input  bomb_drop, userX, userY, collide,
        output bombX, bombY, bombS, bomb_live, blast, hit_count
    );
endinterface

// File: rtl/bomb_ctrl.sv
// bomb_ctrl: frame-clocked bomb fuse/blast sequencer publishing a square region and counting hits.
// Optional macro HIT_CLEAR_EN: a counted hit ends BLAST immediately and parks the region.
module bomb_ctrl #(
    parameter int FUSE_FRAMES     = 120,
    parameter int BLAST_FRAMES    = 30,
    parameter int COOLDOWN_FRAMES = 15,
    parameter int BOMB_SIZE       = 16,
    parameter int BLAST_RADIUS    = 32,
    parameter int TILE_LOG2       = 4,
    parameter int OFF_POS         = 700
) (
    input logic        frame_clk,
    input logic        Reset,
    bomb_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ARMED, BLAST, COOLDOWN} state_t;
    localparam logic [9:0]  OFF      = 10'(OFF_POS);
    localparam logic [9:0]  MASK     = 10'(~((1 << TILE_LOG2) - 1));
    localparam logic [9:0]  RAD      = 10'(BLAST_RADIUS);
    localparam logic [9:0]  SZ_ARMED = 10'(BOMB_SIZE);
    localparam logic [9:0]  SZ_BLAST = 10'(BOMB_SIZE + 2 * BLAST_RADIUS);
    localparam logic [15:0] FUSE_LD  = 16'(FUSE_FRAMES - 1);
    localparam logic [15:0] BLAST_LD = 16'(BLAST_FRAMES - 1);
    localparam logic [15:0] COOL_LD  = 16'(COOLDOWN_FRAMES - 1);
    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [9:0]  px, py, px_n, py_n;
    logic [9:0]  bx, by, bs, bx_n, by_n, bs_n;
    logic        drop_q, pend, pend_n, live_q, blast_q;
    logic        edge_req, hit, done, blast_end;
    logic [2:0]  hits, hits_n;
    assign edge_req = bus.bomb_drop & ~drop_q;
    assign hit      = (state == BLAST) & bus.collide & ~pend;
    assign done     = cnt == 16'd0;
`ifdef HIT_CLEAR_EN
    assign blast_end = done | hit;
`else
    assign blast_end = done;
`endif
    always_comb begin
        state_n = state;
        cnt_n   = cnt - 16'd1;
        px_n    = px;
        py_n    = py;
        pend_n  = pend | hit;
        hits_n  = (hit && hits != 3'd7) ? hits + 3'd1 : hits;
        case (state)
            IDLE: begin
                cnt_n = cnt;
                if (edge_req) begin
                    state_n = ARMED;
                    cnt_n   = FUSE_LD;
                    px_n    = bus.userX & MASK;
                    py_n    = bus.userY & MASK;
                end
            end
            ARMED: if (done) begin
                state_n = BLAST;
                cnt_n   = BLAST_LD;
                pend_n  = 1'b0;
            end
            BLAST: if (blast_end) begin
                state_n = COOLDOWN;
                cnt_n   = COOL_LD;
            end
            default: if (done) state_n = IDLE;
        endcase
        // Outputs are decoded from the next state so they register alongside it.
        bx_n = state_n == ARMED ? px_n : state_n == BLAST ? (px_n < RAD ? 10'd0 : px_n - RAD) : OFF;
        by_n = state_n == ARMED ? py_n : state_n == BLAST ? (py_n < RAD ? 10'd0 : py_n - RAD) : OFF;
        bs_n = state_n == ARMED ? SZ_ARMED : state_n == BLAST ? SZ_BLAST : 10'd0;
    end
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            cnt     <= 16'd0;
            px      <= 10'd0;
            py      <= 10'd0;
            drop_q  <= 1'b1;
            pend    <= 1'b0;
            hits    <= 3'd0;
            bx      <= OFF;
            by      <= OFF;
            bs      <= 10'd0;
            live_q  <= 1'b0;
            blast_q <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            px      <= px_n;
            py      <= py_n;
            drop_q  <= bus.bomb_drop;
            pend    <= pend_n;
            hits    <= hits_n;
            bx      <= bx_n;
            by      <= by_n;
            bs      <= bs_n;
            live_q  <= state_n == ARMED;
            blast_q <= state_n == BLAST;
        end
    end
    assign bus.bombX     = bx;
    assign bus.bombY     = by;
    assign bus.bombS     = bs;
    assign bus.bomb_live = live_q;
    assign bus.blast     = blast_q;
    assign bus.hit_count = hits;
endmodule

// File: tb/tb_bomb_ctrl.sv
// tb_bomb_ctrl: directed and randomized stimulus for bomb_ctrl, checked every frame against a
// time-based reference model (phase derived from frames elapsed since the accepted drop).
module tb_bomb_ctrl;
    localparam int FUSE = 120, BL = 30, CD = 15, OFF = 700, RAD = 32;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0, bad = 0;
    bit   chk_en = 0;
    bomb_ctrl_if bif();
    bomb_ctrl dut (.frame_clk(clk), .Reset(rst), .bus(bif));
    always #5 clk = ~clk;
    int m_t = 0, m_s = 0, m_blen = BL, m_hits = 0, m_px = 0, m_py = 0;
    bit m_busy = 0, m_dq = 1, m_hp = 0;
    int arms = 0;
    bit prev_live = 0;
    // Phase after n frames: 0 idle, 1 armed, 2 blast, 3 cooldown.
    function automatic int ph(int n);
        int e;
        e = n - m_s;
        if (!m_busy || e <= 0) return 0;
        if (e <= FUSE) return 1;
        if (e <= FUSE + m_blen) return 2;
        if (e <= FUSE + m_blen + CD) return 3;
        return 0;
    endfunction
    function automatic int sat(int v);
        return v < RAD ? 0 : v - RAD;
    endfunction
    task automatic check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask
    task automatic adv(int n);
        repeat (n) @(negedge clk);
        #1;
    endtask
    task automatic drv(bit d, int x, int y, bit c);
        bif.bomb_drop = d;
        bif.userX     = 10'(x);
        bif.userY     = 10'(y);
        bif.collide   = c;
    endtask
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_t = 0; m_busy = 0; m_hits = 0; m_dq = 1; m_hp = 0;
        end else begin
            int p;
            p = ph(m_t);
            if (p == 0 && bif.bomb_drop && !m_dq) begin
                m_busy = 1; m_s = m_t; m_blen = BL; m_hp = 0;
                m_px = (int'(bif.userX) / 16) * 16;
                m_py = (int'(bif.userY) / 16) * 16;
            end
            if (p == 2 && bif.collide && !m_hp) begin
                m_hp = 1;
                m_hits = m_hits < 7 ? m_hits + 1 : 7;
`ifdef HIT_CLEAR_EN
                m_blen = m_t - m_s - FUSE;
`endif
            end
            m_dq = bif.bomb_drop;
            m_t++;
        end
    end
    always @(negedge clk) begin
        if (chk_en) begin
            int p, ex, ey, es;
            p  = ph(m_t);
            ex = p == 1 ? m_px : p == 2 ? sat(m_px) : OFF;
            ey = p == 1 ? m_py : p == 2 ? sat(m_py) : OFF;
            es = p == 1 ? 16 : p == 2 ? 80 : 0;
            check("bombX", int'(bif.bombX), ex);
            check("bombY", int'(bif.bombY), ey);
            check("bombS", int'(bif.bombS), es);
            check("bomb_live", int'(bif.bomb_live), int'(p == 1));
            check("blast", int'(bif.blast), int'(p == 2));
            check("hit_count", int'(bif.hit_count), m_hits);
            if (bif.bomb_live && !prev_live) arms++;
            prev_live = bif.bomb_live;
        end
    end
    initial begin
        drv(0, 0, 0, 0);
        #1 rst = 1'b1;
        #1 chk_en = 1;
        adv(2);
        check("rst_bombX", int'(bif.bombX), 700);
        check("rst_bombS", int'(bif.bombS), 0);
        check("rst_hits", int'(bif.hit_count), 0);
        rst = 1'b0;
        adv(1);
        drv(1, 37, 50, 0); adv(1);
        check("arm_bombX", int'(bif.bombX), 32);
        check("arm_bombY", int'(bif.bombY), 48);
        check("arm_bombS", int'(bif.bombS), 16);
        check("arm_live", int'(bif.bomb_live), 1);
        adv(119);
        check("fuse_last_live", int'(bif.bomb_live), 1);
        adv(1);
        check("blast_bombX", int'(bif.bombX), 0);
        check("blast_bombY", int'(bif.bombY), 16);
        check("blast_bombS", int'(bif.bombS), 80);
        check("blast_flag", int'(bif.blast), 1);
        adv(29);
        check("blast_last", int'(bif.blast), 1);
        adv(1);
        check("cool_bombX", int'(bif.bombX), 700);
        check("cool_bombS", int'(bif.bombS), 0);
        check("cool_blast", int'(bif.blast), 0);
        adv(15);
        adv(300 - 166);
        check("held_one_cycle", arms, 1);
        drv(0, 100, 200, 0); adv(1);
        drv(1, 100, 200, 0); adv(1);
        check("rearm_live", int'(bif.bomb_live), 1);
        check("rearm_bombX", int'(bif.bombX), 96);
        check("rearm_bombY", int'(bif.bombY), 192);
        check("rearm_count", arms, 2);
        drv(0, 300, 300, 0); adv(9);
        drv(1, 300, 300, 0); adv(1);
        drv(0, 300, 300, 0); adv(1);
        check("pulse_armed_bombX", int'(bif.bombX), 96);
        adv(114);
        drv(1, 300, 300, 0); adv(1);
        drv(0, 300, 300, 0); adv(1);
        check("pulse_blast_bombX", int'(bif.bombX), 64);
        check("pulse_blast_bombS", int'(bif.bombS), 80);
        adv(25);
        drv(1, 300, 300, 0); adv(1);
        drv(0, 300, 300, 0); adv(11);
        check("pulse_cool_idle", int'(bif.bomb_live), 0);
        check("pulse_no_rearm", arms, 2);
        for (int i = 0; i < 9; i++) begin
            int x, y;
            x = i == 0 ? 3 : int'($urandom_range(0, 639));
            y = i == 0 ? 20 : int'($urandom_range(0, 479));
            drv(0, x, y, 1); adv(1);
            drv(1, x, y, 1); adv(FUSE);
            check("hit_armed_ignored", int'(bif.hit_count), i > 7 ? 7 : i);
            adv(200);
            check("hit_sat", int'(bif.hit_count), i + 1 > 7 ? 7 : i + 1);
        end
        drv(0, 37, 50, 0); adv(1);
        drv(1, 37, 50, 0); adv(60);
        check("mid_fuse_live", int'(bif.bomb_live), 1);
        rst = 1'b1;
        #1;
        check("async_bombX", int'(bif.bombX), 700);
        check("async_bombY", int'(bif.bombY), 700);
        check("async_bombS", int'(bif.bombS), 0);
        check("async_live", int'(bif.bomb_live), 0);
        check("async_hits", int'(bif.hit_count), 0);
        adv(1);
        rst = 1'b0;
        adv(3);
        check("held_through_reset", int'(bif.bomb_live), 0);
        drv(0, 37, 50, 0); adv(1);
        drv(1, 37, 50, 0); adv(FUSE);
        check("post_reset_fuse", int'(bif.bomb_live), 1);
        adv(1);
        check("post_reset_blast", int'(bif.blast), 1);
        adv(200);
`ifdef HIT_CLEAR_EN
        drv(0, 37, 50, 0); adv(1);
        drv(1, 37, 50, 0); adv(1);
        drv(0, 37, 50, 0); adv(FUSE);
        check("hc_blast", int'(bif.blast), 1);
        adv(4);
        drv(0, 37, 50, 1); adv(1);
        drv(0, 37, 50, 0);
        check("hc_parked_blast", int'(bif.blast), 0);
        check("hc_parked_bombX", int'(bif.bombX), 700);
        check("hc_parked_bombS", int'(bif.bombS), 0);
        check("hc_hits", int'(bif.hit_count), 1);
        adv(14);
        drv(1, 37, 50, 0); adv(1);
        check("hc_cool_last", int'(bif.bomb_live), 0);
        drv(0, 37, 50, 0); adv(1);
        drv(1, 37, 50, 0); adv(1);
        check("hc_idle_rearm", int'(bif.bomb_live), 1);
        adv(200);
`endif
        drv(0, 0, 0, 0); adv(1);
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 19) == 0) bif.bomb_drop = ~bif.bomb_drop;
            bif.collide = $urandom_range(0, 3) == 0;
            bif.userX   = 10'($urandom_range(0, 639));
            bif.userY   = 10'($urandom_range(0, 479));
            rst         = $urandom_range(0, 999) == 0;
            adv(1);
        end
        rst = 1'b0;
        adv(2);
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
